// File: rtl/lpm_pkg.sv
// lpm_pkg: shared widths and FSM states for the LPM result serializer
package lpm_pkg;
  localparam int BITS_DEFAULT = 32;
  localparam int LPM_WORDS = 8;
  localparam int LPM_IDX_W = 3;
  typedef enum logic [1:0] {IDLE, SEND, DONE} lpm_state_t;
endpackage

// File: rtl/lpm_result_bank.sv
// lpm_result_bank: 8-word register file with parallel load and one indexed read port
module lpm_result_bank
  import lpm_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_load,
  input  logic [LPM_WORDS-1:0][BITS-1:0]  i_data,
  input  logic [LPM_IDX_W-1:0]            i_idx,
  output logic [BITS-1:0]                 o_data
);
  logic [LPM_WORDS-1:0][BITS-1:0] r_bank;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_bank <= '0;
    else if (i_load) r_bank <= i_data;
  assign o_data = r_bank[i_idx];
endmodule

// File: rtl/lpm_result_serializer.sv
// lpm_result_serializer: captures eight LPM result words and streams them over valid/ready with a running checksum
module lpm_result_serializer
  import lpm_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BITS-1:0]       in1,
  input  logic [BITS-1:0]       in2,
  input  logic [BITS-1:0]       in3,
  input  logic [BITS-1:0]       in4,
  input  logic [BITS-1:0]       in5,
  input  logic [BITS-1:0]       in6,
  input  logic [BITS-1:0]       in7,
  input  logic [BITS-1:0]       in8,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [BITS-1:0]       out_data,
  output logic [LPM_IDX_W-1:0]  out_index,
  output logic                  busy,
  output logic                  done,
  output logic [BITS-1:0]       checksum
);
  lpm_state_t             r_state;
  logic [LPM_IDX_W-1:0]   r_idx;
  logic                   r_valid;
  logic                   r_done;
  logic [BITS-1:0]        r_sum;
  logic [BITS-1:0]        w_rd;
  logic                   w_load;
  logic                   w_xfer;
  logic                   w_last;
  assign w_load = (r_state == IDLE) && start;
  assign w_xfer = r_valid && out_ready;
  assign w_last = r_idx == LPM_IDX_W'(LPM_WORDS - 1);
  // index 0 of the bank is in1, so in1 sits in the low word of the packed bus
  lpm_result_bank #(.BITS(BITS)) u_bank (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_load (w_load),
    .i_data ({in8, in7, in6, in5, in4, in3, in2, in1}),
    .i_idx  (r_idx),
    .o_data (w_rd)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= SEND;
          r_idx   <= '0;
          r_valid <= 1'b1;
          r_sum   <= '0;
        end
        SEND: if (w_xfer) begin
          r_sum <= r_sum + w_rd;
          if (w_last) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else r_idx <= r_idx + LPM_IDX_W'(1);
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  assign out_valid = r_valid;
  assign out_data  = w_rd;
  assign out_index = r_idx;
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign checksum  = r_sum;
endmodule

// File: tb/tb_lpm_result_serializer.sv
// tb_lpm_result_serializer: directed table and sequence checks for the LPM result serializer
module tb_lpm_result_serializer;
  logic        clock = 1'b0;
  logic        reset, start, out_ready;
  logic [31:0] in1, in2, in3, in4, in5, in6, in7, in8;
  logic        out_valid, busy, done;
  logic [31:0] out_data, checksum;
  logic [2:0]  out_index;
  int checks = 0;
  int failures = 0;

  lpm_result_serializer #(.BITS(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rdy;
    logic        v;
    logic [31:0] d;
    logic [2:0]  ix;
    logic        dn;
    logic        bz;
    logic [31:0] s;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [31:0] base, input logic [31:0] step);
    in1 = base;          in2 = base + step;     in3 = base + 2*step; in4 = base + 3*step;
    in5 = base + 4*step; in6 = base + 5*step;   in7 = base + 6*step; in8 = base + 7*step;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic stream_check(input logic [31:0] base, input logic [31:0] step,
                              input logic [31:0] exp_sum, input bit scramble, input bit poke);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, base + i * step);
      chk("stream_index", {29'd0, out_index}, i);
      if (scramble) set_in($urandom, $urandom);
      start = poke && (i == 3 || i == 7);
      if (start) set_in(32'hAAAAAAAA, 32'd0);
      @(negedge clock);
    end
    start = 1'b0;
    chk("stream_done", {31'd0, done}, 32'd1);
    chk("stream_done_valid", {31'd0, out_valid}, 32'd0);
    chk("stream_sum", checksum, exp_sum);
    @(negedge clock);
    chk("stream_idle_done", {31'd0, done}, 32'd0);
    chk("stream_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    chk("stream_no_recapture", {31'd0, out_valid}, 32'd0);
    chk("stream_sum_hold", checksum, exp_sum);
  endtask

  initial begin
    int cyc;
    logic [31:0] es;
    logic [2:0] ei;
    bit fin;
    for (int i = 0; i < 8; i++) tv[i] = '{1'b1, 1'b1, 32'(i + 1), 3'(i), 1'b0, 1'b1, 32'(i * (i + 1) / 2)};
    tv[8] = '{1'b1, 1'b0, 32'd0, 3'd0, 1'b1, 1'b1, 32'd36};
    tv[9] = '{1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd36};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; set_in(32'd1, 32'd1);
    @(negedge clock); @(negedge clock);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", {29'd0, out_index}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum", checksum, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", {31'd0, busy}, 0);

    // basic stream from the table, ready held high
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      out_ready = tv[i].rdy;
      chk("tbl_valid", {31'd0, out_valid}, {31'd0, tv[i].v});
      if (tv[i].v) begin
        chk("tbl_data", out_data, tv[i].d);
        chk("tbl_index", {29'd0, out_index}, {29'd0, tv[i].ix});
      end
      chk("tbl_done", {31'd0, done}, {31'd0, tv[i].dn});
      chk("tbl_busy", {31'd0, busy}, {31'd0, tv[i].bz});
      chk("tbl_sum", checksum, tv[i].s);
      @(negedge clock);
    end

    // back-pressure: ready low on alternate cycles, done 17 cycles after start
    set_in(32'd1, 32'd1);
    pulse_start();
    es = 0; ei = 0; fin = 0; cyc = 1;
    while (!fin && cyc < 40) begin
      out_ready = cyc[0] == 1'b0;
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_data", out_data, 32'(ei) + 1);
      chk("bp_index", {29'd0, out_index}, {29'd0, ei});
      chk("bp_sum", checksum, es);
      if (out_ready) begin
        es = es + 32'(ei) + 1;
        fin = ei == 3'd7;
        ei = ei + 3'd1;
      end
      @(negedge clock);
      cyc++;
    end
    chk("bp_done_cycle", cyc, 17);
    chk("bp_done", {31'd0, done}, 1);
    chk("bp_final_sum", checksum, 36);
    @(negedge clock);

    set_in(32'hFFFFFFFF, 32'd0);
    pulse_start();
    stream_check(32'hFFFFFFFF, 32'd0, 32'hFFFFFFF8, 1'b0, 1'b0);

    set_in(32'd1, 32'd1);
    pulse_start();
    stream_check(32'd1, 32'd1, 32'd36, 1'b0, 1'b1);

    // reset abandons a partial stream after word 4 transfers
    set_in(32'd1, 32'd1);
    pulse_start();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clock);
    chk("mid_index", {29'd0, out_index}, 5);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_index", {29'd0, out_index}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_sum", checksum, 0);
    @(negedge clock);
    reset = 1'b0;
    set_in(32'd10, 32'd1);
    @(negedge clock);
    pulse_start();
    stream_check(32'd10, 32'd1, 32'd108, 1'b0, 1'b0);

    set_in(32'd100, 32'd1);
    pulse_start();
    stream_check(32'd100, 32'd1, 32'd828, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
